// File: rtl/stream_arb2.sv
// stream_arb2: two-input, packet-locked, round-robin stream arbiter.
// A grant, once issued, stays on one input until that input's last beat
// transfers. Accepted beats land in a single registered output stage that
// can be reloaded in the same cycle it is drained. `sel` mirrors the
// current grant so a downstream mux2to1 can follow it.
// Optional feature: define STREAM_ARB2_PKT_CNT_EN to add per-input
// completed-packet counters (pkt_cnt_a, pkt_cnt_b, CNT_W bits each).
module stream_arb2 #(
    parameter int DATA_W = 8
`ifdef STREAM_ARB2_PKT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sel
`ifdef STREAM_ARB2_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]  pkt_cnt_a,
    output logic [CNT_W-1:0]  pkt_cnt_b
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    state_t             state_r;
    state_t             next_s;
    logic               last_winner_r;   // 0 = A won last, 1 = B won last
    logic               last_winner_s;
    logic               sel_r;
    logic               sel_s;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_data_r;
    logic               out_last_r;
    logic               load_s;
    logic               a_ready_s;
    logic               b_ready_s;
    logic               a_xfer_s;
    logic               b_xfer_s;

    // Handshake decode: a beat may enter only when the output slot is free or draining.
    always_comb begin
        load_s    = (!out_valid_r) || out_ready;
        a_ready_s = (state_r == GNT_A) && load_s;
        b_ready_s = (state_r == GNT_B) && load_s;
        a_xfer_s  = a_valid && a_ready_s;
        b_xfer_s  = b_valid && b_ready_s;
    end

    // Next-state logic: round-robin in IDLE, packet lock while granted.
    always_comb begin
        next_s        = state_r;
        last_winner_s = last_winner_r;
        case (state_r)
            IDLE: begin
                if (a_valid && b_valid) begin
                    next_s = last_winner_r ? GNT_A : GNT_B;
                end else if (a_valid) begin
                    next_s = GNT_A;
                end else if (b_valid) begin
                    next_s = GNT_B;
                end else begin
                    next_s = IDLE;
                end
            end
            GNT_A: begin
                if (a_xfer_s && a_last) begin
                    last_winner_s = 1'b0;
                    if (b_valid) begin
                        next_s = GNT_B;
                    end else if (a_valid) begin
                        next_s = GNT_A;
                    end else begin
                        next_s = IDLE;
                    end
                end else begin
                    next_s = GNT_A;
                end
            end
            GNT_B: begin
                if (b_xfer_s && b_last) begin
                    last_winner_s = 1'b1;
                    if (a_valid) begin
                        next_s = GNT_A;
                    end else if (b_valid) begin
                        next_s = GNT_B;
                    end else begin
                        next_s = IDLE;
                    end
                end else begin
                    next_s = GNT_B;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Select follows the grant; IDLE keeps whatever was last selected.
    always_comb begin
        case (next_s)
            GNT_A:   sel_s = 1'b0;
            GNT_B:   sel_s = 1'b1;
            default: sel_s = sel_r;
        endcase
    end

    // Arbitration state, round-robin history and select register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            last_winner_r <= 1'b1;
            sel_r         <= 1'b0;
        end else begin
            state_r       <= next_s;
            last_winner_r <= last_winner_s;
            sel_r         <= sel_s;
        end
    end

    // Output register: load on transfer, clear when drained with nothing new.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
        end else if (a_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= a_data;
            out_last_r  <= a_last;
        end else if (b_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= b_data;
            out_last_r  <= b_last;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef STREAM_ARB2_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_cnt_a_r;
    logic [CNT_W-1:0] pkt_cnt_b_r;

    // Completed-packet counters; natural wrap from all-ones to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_a_r <= {CNT_W{1'b0}};
            pkt_cnt_b_r <= {CNT_W{1'b0}};
        end else begin
            if (a_xfer_s && a_last) begin
                pkt_cnt_a_r <= pkt_cnt_a_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (b_xfer_s && b_last) begin
                pkt_cnt_b_r <= pkt_cnt_b_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pkt_cnt_a = pkt_cnt_a_r;
    assign pkt_cnt_b = pkt_cnt_b_r;
`endif

    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign sel       = sel_r;

endmodule

// File: tb/tb_stream_arb2.sv
// tb_stream_arb2: directed scenarios for stream_arb2 with a per-cycle
// reference model (grant owner, output slot, queue of accepted beats)
// plus literal expectations on output order and select sequence.
module tb_stream_arb2;

    localparam int DW = 8;
`ifdef STREAM_ARB2_PKT_CNT_EN
    localparam int CW = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, a_ready, a_last;
    logic [DW-1:0] a_data;
    logic          b_valid, b_ready, b_last;
    logic [DW-1:0] b_data;
    logic          out_valid, out_ready, out_last, sel;
    logic [DW-1:0] out_data;
`ifdef STREAM_ARB2_PKT_CNT_EN
    logic [CW-1:0] pkt_cnt_a, pkt_cnt_b;
`endif

    always #5 clk = ~clk;

`ifdef STREAM_ARB2_PKT_CNT_EN
    stream_arb2 #(.DATA_W(DW), .CNT_W(CW)) dut (
`else
    stream_arb2 #(.DATA_W(DW)) dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sel(sel)
`ifdef STREAM_ARB2_PKT_CNT_EN
        , .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 none, 1 A, 2 B ; prev: 1 A won last, 2 B won last
    int         m_owner;
    int         m_prev;
    bit         m_init = 1'b0;
    logic       m_ov, m_ol, m_sel;
    logic [7:0] m_od;
    int         m_cnt_a, m_cnt_b;
    logic [8:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       sel_q[$];

    bit e_ar, e_br, load, at, bt;

    // Compare DUT against the model mid-cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        if (m_init) begin
            load = !m_ov || out_ready;
            e_ar = (m_owner == 1) && load;
            e_br = (m_owner == 2) && load;
            chk("a_ready", {31'd0, a_ready}, {31'd0, e_ar});
            chk("b_ready", {31'd0, b_ready}, {31'd0, e_br});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            chk("sel", {31'd0, sel}, {31'd0, m_sel});
            if (m_ov) begin
                chk("out_data", {24'd0, out_data}, {24'd0, m_od});
                chk("out_last", {31'd0, out_last}, {31'd0, m_ol});
            end
`ifdef STREAM_ARB2_PKT_CNT_EN
            chk("pkt_cnt_a", {30'd0, pkt_cnt_a}, m_cnt_a);
            chk("pkt_cnt_b", {30'd0, pkt_cnt_b}, m_cnt_b);
`endif
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    chk("order_extra_beat", {23'd0, out_last, out_data}, 32'h1ff);
                end else begin
                    chk("order", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
                end
            end
        end
        if (rst_n !== 1'b1) begin
            m_owner = 0; m_prev = 2; m_ov = 1'b0; m_ol = 1'b0; m_od = 8'h00;
            m_sel = 1'b0; m_cnt_a = 0; m_cnt_b = 0; exp_q.delete(); m_init = 1'b1;
        end else if (m_init) begin
            load = !m_ov || out_ready;
            at = a_valid && (m_owner == 1) && load;
            bt = b_valid && (m_owner == 2) && load;
            if (at) begin
                exp_q.push_back({a_last, a_data});
                m_ov = 1'b1; m_od = a_data; m_ol = a_last;
            end else if (bt) begin
                exp_q.push_back({b_last, b_data});
                m_ov = 1'b1; m_od = b_data; m_ol = b_last;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (m_owner == 0) begin
                if (a_valid && b_valid) m_owner = (m_prev == 2) ? 1 : 2;
                else if (a_valid) m_owner = 1;
                else if (b_valid) m_owner = 2;
            end else if (at && a_last) begin
                m_prev = 1; m_cnt_a = (m_cnt_a + 1) % 4;
                m_owner = b_valid ? 2 : (a_valid ? 1 : 0);
            end else if (bt && b_last) begin
                m_prev = 2; m_cnt_b = (m_cnt_b + 1) % 4;
                m_owner = a_valid ? 1 : (b_valid ? 2 : 0);
            end
            if (m_owner == 1) m_sel = 1'b0;
            else if (m_owner == 2) m_sel = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pkt(input int port, input int n, input logic [7:0] d0, input logic [7:0] step);
        logic [7:0] d;
        bit done;
        for (int i = 0; i < n; i++) begin
            d = d0 + step * 8'(i);
            if (port == 0) begin
                a_valid = 1'b1; a_data = d; a_last = (i == n - 1);
            end else begin
                b_valid = 1'b1; b_data = d; b_last = (i == n - 1);
            end
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk);
                if ((port == 0) ? (a_ready === 1'b1) : (b_ready === 1'b1)) begin
                    done = 1'b1;
                    sel_q.push_back(sel);
                end
            end
            if (!done) chk("send_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        if (port == 0) a_valid = 1'b0; else b_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete(); sel_q.delete();
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = 8'h00; b_data = 8'h00; out_ready = 1'b1;

        // Reset check
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        rst_n = 1'b1;

        // Single 3-beat A packet
        got_q.delete(); sel_q.delete();
        send_pkt(0, 3, 8'h11, 8'h11);
        drain();
        chk("single_count", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            chk("single_b0", {24'd0, got_q[0]}, 32'h11);
            chk("single_b1", {24'd0, got_q[1]}, 32'h22);
            chk("single_b2", {24'd0, got_q[2]}, 32'h33);
        end
        chk("single_sel", {31'd0, sel}, 32'd0);

        // Tie round-robin from reset
        do_reset();
        fork
            begin send_pkt(0, 1, 8'hA1, 8'h00); send_pkt(0, 1, 8'hA2, 8'h00); end
            begin send_pkt(1, 1, 8'hB1, 8'h00); send_pkt(1, 1, 8'hB2, 8'h00); end
        join
        drain();
        chk("rr_count", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            chk("rr_0", {24'd0, got_q[0]}, 32'hA1);
            chk("rr_1", {24'd0, got_q[1]}, 32'hB1);
            chk("rr_2", {24'd0, got_q[2]}, 32'hA2);
            chk("rr_3", {24'd0, got_q[3]}, 32'hB2);
        end
        if (sel_q.size() == 4) begin
            chk("rr_sel_seq", {28'd0, sel_q[0], sel_q[1], sel_q[2], sel_q[3]}, 32'b0101);
        end else begin
            chk("rr_sel_count", sel_q.size(), 32'd4);
        end

        // Packet lock: B raised during A's beat 2
        do_reset();
        fork
            send_pkt(0, 4, 8'h41, 8'h01);
            begin repeat (2) @(posedge clk); #1; send_pkt(1, 1, 8'hB7, 8'h00); end
        join
        drain();
        chk("lock_count", got_q.size(), 32'd5);
        if (got_q.size() == 5) begin
            chk("lock_3", {24'd0, got_q[3]}, 32'h44);
            chk("lock_4", {24'd0, got_q[4]}, 32'hB7);
        end

        // Backpressure: out_ready low for 5 cycles mid-packet
        do_reset();
        fork
            send_pkt(0, 4, 8'h61, 8'h01);
            begin
                repeat (3) @(posedge clk); #1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_hold_data", {24'd0, out_data}, 32'h62);
                    chk("bp_hold_last", {31'd0, out_last}, 32'd0);
                    chk("bp_a_ready", {31'd0, a_ready}, 32'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            chk("bp_0", {24'd0, got_q[0]}, 32'h61);
            chk("bp_1", {24'd0, got_q[1]}, 32'h62);
            chk("bp_2", {24'd0, got_q[2]}, 32'h63);
            chk("bp_3", {24'd0, got_q[3]}, 32'h64);
        end

        // Reset in the middle of a B packet
        do_reset();
        b_valid = 1'b1; b_data = 8'h51; b_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_data = 8'h52;
        @(posedge clk); #1;
        rst_n = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sel", {31'd0, sel}, 32'd0);
        chk("mid_rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
        rst_n = 1'b1;
        got_q.delete(); sel_q.delete();
        fork
            send_pkt(0, 1, 8'hC1, 8'h00);
            send_pkt(1, 1, 8'hD1, 8'h00);
        join
        drain();
        chk("post_rst_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            chk("post_rst_first", {24'd0, got_q[0]}, 32'hC1);
        end

`ifdef STREAM_ARB2_PKT_CNT_EN
        // Counter wrap: 5 A packets with a 2-bit counter
        do_reset();
        for (int p = 0; p < 5; p++) send_pkt(0, 1, 8'h70 + 8'(p), 8'h00);
        drain();
        chk("cnt_a_wrap", {30'd0, pkt_cnt_a}, 32'd1);
        chk("cnt_b_zero", {30'd0, pkt_cnt_b}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
